// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier sequencer: default widths, FIFO entry and FSM states.
// BOOTH_SEQ_TAG_EN adds a tag field to the FIFO entry.
package booth_pkg;

  localparam int unsigned BoothWidth = 4;
  localparam int unsigned BoothTagW  = 4;

  typedef struct packed {
`ifdef BOOTH_SEQ_TAG_EN
    logic [BoothTagW-1:0]  tag;
`endif
    logic [BoothWidth-1:0] m;
    logic [BoothWidth-1:0] q;
  } booth_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait
  } booth_state_e;

endpackage

// File: rtl/booth_seq_fifo.sv
// Synchronous FIFO for booth_seq operand pairs; Depth must be a power of two (>= 2).
module booth_seq_fifo #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  entry_t                 wdata_i,
  input  logic                   pop_i,
  output entry_t                 rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW:0]   count_q, count_d;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/booth_seq.sv
// Operand sequencer and result buffer around the fixed-latency Booth multiplier.
// Define BOOTH_SEQ_TAG_EN to carry a TAG_W-bit tag from in_tag to out_tag alongside each product.
module booth_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH      = BoothWidth,
  parameter int unsigned MULT_LAT   = 5,
  parameter int unsigned FIFO_DEPTH = 2
`ifdef BOOTH_SEQ_TAG_EN
  ,
  parameter int unsigned TAG_W      = BoothTagW
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_q,
`ifdef BOOTH_SEQ_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int unsigned CntW = $clog2(MULT_LAT + 1);

  typedef struct packed {
`ifdef BOOTH_SEQ_TAG_EN
    logic [TAG_W-1:0] tag;
`endif
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
  } entry_t;

  entry_t                      push_entry, head;
  logic                        push, pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  booth_state_e       state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mul_m_q, mul_m_d, mul_q_q, mul_q_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_p_q, out_p_d;
`ifdef BOOTH_SEQ_TAG_EN
  logic [TAG_W-1:0]   tag_q, tag_d, out_tag_q, out_tag_d;
`endif

  assign push = in_valid && !fifo_full;

  always_comb begin
    push_entry   = '0;
    push_entry.m = in_m;
    push_entry.q = in_q;
`ifdef BOOTH_SEQ_TAG_EN
    push_entry.tag = in_tag;
`endif
  end

  booth_seq_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    mul_load    = 1'b0;
`ifdef BOOTH_SEQ_TAG_EN
    tag_d       = tag_q;
    out_tag_d   = out_tag_q;
`endif
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          mul_m_d = head.m;
          mul_q_d = head.q;
`ifdef BOOTH_SEQ_TAG_EN
          tag_d   = head.tag;
`endif
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        mul_load = 1'b1;
        cnt_d    = CntW'(MULT_LAT - 1);
        state_d  = StWait;
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!out_valid_q) begin
          // A pending result blocks capture, so nothing is ever overwritten.
          out_p_d     = mul_p;
          out_valid_d = 1'b1;
`ifdef BOOTH_SEQ_TAG_EN
          out_tag_d   = tag_q;
`endif
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
`ifdef BOOTH_SEQ_TAG_EN
      tag_q       <= '0;
      out_tag_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
`ifdef BOOTH_SEQ_TAG_EN
      tag_q       <= tag_d;
      out_tag_q   <= out_tag_d;
`endif
    end
  end

  assign in_ready  = !fifo_full;
  assign mul_m     = mul_m_q;
  assign mul_q     = mul_q_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = (state_q != StIdle) || (fifo_count != '0);
`ifdef BOOTH_SEQ_TAG_EN
  assign out_tag   = out_tag_q;
`endif

endmodule

// File: tb/tb_booth_seq.sv
// Randomised self-checking bench for booth_seq with a behavioural multiplier and scoreboard.
module tb_booth_seq;

  localparam int unsigned W     = 4;
  localparam int unsigned LAT   = 5;
  localparam int unsigned DEPTH = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_m, in_q;
  logic [3:0]     in_tag;
  logic           mul_load;
  logic [W-1:0]   mul_m, mul_q;
  logic [2*W-1:0] mul_p;
  logic           out_valid, out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;
`ifdef BOOTH_SEQ_TAG_EN
  logic [3:0]     out_tag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  int n_out    = 0;
  logic [2*W-1:0] last_p;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  booth_seq #(
    .WIDTH      (W),
    .MULT_LAT   (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_m      (in_m),
    .in_q      (in_q),
`ifdef BOOTH_SEQ_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .mul_load  (mul_load),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return (2*W)'(sa * sb);
  endfunction

  // Multiplier model: P is wrong until LAT clocks after the load cycle.
  logic [W-1:0] mm, mq;
  int           mcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm <= '0; mq <= '0; mcnt <= 0;
    end else if (mul_load) begin
      mm <= mul_m; mq <= mul_q; mcnt <= LAT - 1;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign mul_p = (mcnt == 0 && !mul_load) ? prod(mm, mq) : (prod(mm, mq) ^ 8'h5A);

  // Scoreboard, in push order.
  logic [2*W-1:0] exp_p[$];
  logic [W-1:0]   exp_m[$], exp_q[$];
  logic [3:0]     exp_t[$];
  bit             hold_prev = 1'b0;
  logic [2*W-1:0] hold_p;

  always @(negedge clk) begin
    if (reset) begin
      exp_p.delete(); exp_m.delete(); exp_q.delete(); exp_t.delete();
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_p.push_back(prod(in_m, in_q));
        exp_m.push_back(in_m);
        exp_q.push_back(in_q);
        exp_t.push_back(in_tag);
      end
      if (mul_load) begin
        n_loads++;
        if (exp_m.size() == 0) check_eq("load_spurious", 1, 0);
        else begin
          check_eq("load_m", mul_m, exp_m.pop_front());
          check_eq("load_q", mul_q, exp_q.pop_front());
        end
      end
      if (mcnt > 0) begin
        check_eq("mul_m_stable", mul_m, mm);
        check_eq("mul_q_stable", mul_q, mq);
      end
      if (hold_prev) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_p", out_p, hold_p);
      end
      hold_prev = out_valid && !out_ready;
      hold_p    = out_p;
      if (out_valid && out_ready) begin
        n_out++;
        last_p = out_p;
        if (exp_p.size() == 0) check_eq("out_spurious", 1, 0);
        else begin
          check_eq("out_p", out_p, exp_p.pop_front());
`ifdef BOOTH_SEQ_TAG_EN
          check_eq("out_tag", out_tag, exp_t.pop_front());
`else
          void'(exp_t.pop_front());
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] m, input logic [W-1:0] q, input logic [3:0] tag);
    int  guard = 0;
    bit  rdy;
    in_valid = 1'b1; in_m = m; in_q = q; in_tag = tag;
    forever begin
      rdy = in_ready;
      step();
      if (rdy) break;
      if (++guard > 200) begin
        check_eq("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    while ((exp_p.size() != 0 || busy || out_valid) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_done", n < budget, 1);
  endtask

  initial begin
    int n, base;
    reset = 1'b1; in_valid = 1'b0; in_m = '0; in_q = '0; in_tag = '0; out_ready = 1'b0;
    #22 reset = 1'b0;
    step();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_mul_load", mul_load, 0);
    check_eq("rst_mul_m", mul_m, 0);
    check_eq("rst_mul_q", mul_q, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_p", out_p, 0);
    check_eq("rst_busy", busy, 0);

    // Single pair: enqueue to out_valid is LAT+3 cycles.
    out_ready = 1'b1;
    base = n_loads;
    send(4'h3, 4'hE, 4'h0);
    n = 1;
    while (!out_valid && n < 30) begin step(); n++; end
    check_eq("t1_latency", n, LAT + 3);
    check_eq("t1_out_p", out_p, 8'hFA);
    check_eq("t1_loads", n_loads - base, 1);
    drain(40);

    // Back-to-back with tags.
    base = n_out;
    send(4'h7, 4'h7, 4'hA);
    send(4'h8, 4'h8, 4'h5);
    drain(60);
    check_eq("t2_count", n_out - base, 2);
    check_eq("t2_last", last_p, 8'h40);

    // Back-pressure: fill FIFO with one result pending and one multiply stalled.
    out_ready = 1'b0;
    base = n_out;
    send(4'h8, 4'h7, 4'h1);
    send(4'h2, 4'h3, 4'h2);
    send(4'hF, 4'h5, 4'h3);
    send(4'h6, 4'hA, 4'h4);
    repeat (2 * LAT) step();
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    check_eq("bp_out_p", out_p, 8'hC8);
    check_eq("bp_busy", busy, 1);
    drain(100);
    check_eq("bp_count", n_out - base, 4);

    // Push and pop on the same edge with one entry queued.
    out_ready = 1'b1;
    send(4'h1, 4'h2, 4'h6);
    send(4'h3, 4'h3, 4'h7);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    send(4'hC, 4'h4, 4'h8);
    check_eq("pp_count", dut.u_fifo.count_q, 1);
    check_eq("pp_load", mul_load, 1);
    drain(60);

    // Asynchronous reset in WAIT with the counter at 2.
    send(4'h5, 4'h3, 4'h9);
    n = 0;
    while (!mul_load && n < 20) begin step(); n++; end
    repeat (3) step();
    check_eq("rw_cnt", dut.cnt_q, 2);
    #2 reset = 1'b1;
    #1;
    check_eq("rw_out_valid", out_valid, 0);
    check_eq("rw_mul_load", mul_load, 0);
    check_eq("rw_busy", busy, 0);
    check_eq("rw_in_ready", in_ready, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    check_eq("rw_post_load", mul_load, 0);
    send(4'h1, 4'h1, 4'hB);
    drain(40);
    check_eq("rw_result", last_p, 8'h01);

    // Random traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send(W'($urandom), W'($urandom), 4'($urandom));
      rand_rdy = 1'b1;
    end
    drain(400);
    check_eq("sb_empty", exp_p.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
